dc_token_ring_reader_mram: RTL and testbench
============================================

# dc_token_ring_reader_mram

Read-side controller of the MRAM dual-clock token-ring FIFO in the uDMA external-peripheral path. It is the consumer counterpart of the write-side full detector. It owns the one-hot read pointer and selects the addressed entry from the write-domain data buffer. It decides when a pop is safe using synchronised occupancy flags, and presents data through a registered valid/ready output stage.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one FIFO entry
- BUFFER_DEPTH, 8, number of entries (one-hot pointer width); must be ≥ 4

Ports:
- clk  in  1  read-domain clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- write_pointer  in  BUFFER_DEPTH  one-hot write pointer from the write domain (asynchronous to clk)
- buffer_data  in  BUFFER_DEPTH*DATA_WIDTH  flattened buffer contents; entry i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- read_pointer  out  BUFFER_DEPTH  one-hot read pointer, exported to the write-side full detector
- data_o  out  DATA_WIDTH  output data
- valid_o  out  1  data_o holds a valid entry
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i
- empty_o  out  1  no pop is currently permitted (can_read low)

## Operation
- The occupancy flags are combinational in mixed domains and are evaluated on the raw pointers:
  - empty = |(read_pointer & write_pointer)
  - one_used = |(write_pointer & rotl(read_pointer,1))
  - two_used = |(write_pointer & rotl(read_pointer,2))
  - rotl(p,n) = {p[D-1-n:0], p[D-1:D-n]}
- avail1_dn = ~empty; avail3_dn = ~(empty | one_used | two_used).
- Both flags pass through one dc_synchronizer, WIDTH 2, RESET_VALUE 2'b00, producing avail1_up and avail3_up.
- Guard counter, 2 bits:
  - Loaded with 2 on every pop.
  - Otherwise decrements to 0.
- can_read = avail3_up | (avail1_up & guard == 0).
  - Fast path (avail3_up): back-to-back pops at full rate. A flag sampled 2 cycles ago showing ≥3 entries covers the 2 pops made since, so the fast path is safe.
  - Slow path: at most 1 pop per 3 cycles, until the synchronised flag reflects the advanced pointer.
- pop = can_read & (~valid_o | ready_i).
- On pop:
  - data_o <= entry selected by read_pointer (AND-OR mux).
  - valid_o <= 1.
  - read_pointer <= rotl(read_pointer,1), wrapping from bit D-1 to bit 0.
- On valid_o & ready_i without pop: valid_o <= 0 and data_o holds its value.
- empty_o = ~can_read.
- No other state exists; no pop can occur without can_read.

## Timing
- Reset values:
  - read_pointer = 1 (bit 0); this equals the write side's reset pointer, so the FIFO is empty.
  - data_o = 0, valid_o = 0.
  - guard = 0.
  - avail1_up = avail3_up = 0, so empty_o = 1.
- First-word latency:
  - write_pointer advances from empty before rising edge k.
  - avail1_up is high after edge k+1.
  - The pop occurs on edge k+2; valid_o = 1 after edge k+2.
- Throughput:
  - 1 entry/cycle while avail3_up = 1.
  - 1 entry per 3 cycles when only 1–2 entries are visible.
- Pop and consume in the same cycle: valid_o stays 1 and data_o takes the new entry with no bubble.
- ready_i low with valid_o high: no pop; data_o and valid_o remain stable; read_pointer is frozen.
- Wrap-around: the pointer rotates modulo BUFFER_DEPTH; the flags are rotation-invariant.
- When writes arrive while the guard is running, avail3_up overrides the guard once it is synchronised.
- Mid-operation rstn assertion:
  - All state returns to reset values asynchronously and any buffered entries are abandoned.
  - The write side is reset by the same system reset.

## Test plan
- Reset: hold rstn low for 3 cycles, write_pointer = 1 → read_pointer = 8'h01, valid_o = 0, data_o = 0, empty_o = 1; all values hold for 5 cycles after release.
- Single word: buffer entry 0 = 32'hA5A5_0001, write_pointer → 8'h02 before edge k, ready_i = 1 → valid_o high after edge k+2 with data_o = 32'hA5A5_0001; read_pointer = 8'h02; no second pop.
- Slow path: 2 entries written, ready_i = 1 → pops exactly 3 cycles apart; read_pointer goes 01→02→04; empty_o = 1 afterwards.
- Burst and wrap-around: write 12 entries into a depth-8 FIFO (writer limited by full), ready_i = 1 → data emerges in order with no duplicates or losses; consecutive-cycle pops while ≥3 entries are pending; read_pointer wraps from 8'h80 to 8'h01.
- Back-pressure: 4 entries pending, ready_i low for 6 cycles → one word is held stable and read_pointer advances once only; when ready_i rises, the remaining words follow with no bubble.
- Reset mid-burst: assert rstn during a fast-path burst → outputs return to reset values immediately; after release with write_pointer = 1, no spurious valid_o appears.

Source files
------------

// File: rtl/dc_token_ring_reader_mram_if.sv
// Signal bundle between the MRAM token-ring read controller and its environment:
// write-domain pointer/buffer inputs, exported read pointer and the valid/ready output stage.
interface dc_token_ring_reader_mram_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
);
    logic [BUFFER_DEPTH-1:0]            write_pointer;
    logic [BUFFER_DEPTH*DATA_WIDTH-1:0] buffer_data;
    logic [BUFFER_DEPTH-1:0]            read_pointer;
    logic [DATA_WIDTH-1:0]              data_o;
    logic                               valid_o;
    logic                               ready_i;
    logic                               empty_o;

    modport master (
        output write_pointer, buffer_data, ready_i,
        input  read_pointer, data_o, valid_o, empty_o
    );

    modport slave (
        input  write_pointer, buffer_data, ready_i,
        output read_pointer, data_o, valid_o, empty_o
    );
endinterface

// File: rtl/dc_token_ring_reader_mram.sv
// Read-side controller of the MRAM dual-clock token-ring FIFO: one-hot read pointer,
// synchronised occupancy flags with a pop guard, and a registered valid/ready output.

module dc_synchronizer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-flop re-timing of the asynchronous flag vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= data_in;
            sync_r <= meta_r;
        end
    end

    assign data_out = sync_r;
endmodule

module dc_token_ring_reader_mram #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input logic                        clk,
    input logic                        rstn,
    dc_token_ring_reader_mram_if.slave bus
);
    localparam logic [BUFFER_DEPTH-1:0] PTR_RESET = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};

    function automatic logic [BUFFER_DEPTH-1:0] rotl(input logic [BUFFER_DEPTH-1:0] p, input int n);
        rotl = (p << n) | (p >> (BUFFER_DEPTH - n));
    endfunction

    logic [BUFFER_DEPTH-1:0] read_pointer_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    valid_r;
    logic [1:0]              guard_r;

    logic                    empty_s;
    logic                    one_used_s;
    logic                    two_used_s;
    logic [1:0]              avail_dn_s;
    logic [1:0]              avail_up_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    can_read_s;
    logic                    pop_s;

    // Flags are mixed-domain on purpose; only their synchronised copies feed can_read.
    always_comb begin
        empty_s    = |(read_pointer_r & bus.write_pointer);
        one_used_s = |(bus.write_pointer & rotl(read_pointer_r, 1));
        two_used_s = |(bus.write_pointer & rotl(read_pointer_r, 2));
        avail_dn_s = {~(empty_s | one_used_s | two_used_s), ~empty_s};
        sel_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < BUFFER_DEPTH; i++) begin
            sel_data_s = sel_data_s |
                (bus.buffer_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{read_pointer_r[i]}});
        end
        can_read_s = avail_up_s[1] | (avail_up_s[0] & (guard_r == 2'd0));
        pop_s      = can_read_s & (~valid_r | bus.ready_i);
    end

    dc_synchronizer #(
        .WIDTH       (2),
        .RESET_VALUE (2'b00)
    ) u_avail_sync (
        .clk      (clk),
        .rstn     (rstn),
        .data_in  (avail_dn_s),
        .data_out (avail_up_s)
    );

    // Guard holds off slow-path pops until the flag reflects the advanced pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            guard_r <= 2'd0;
        end else if (pop_s) begin
            guard_r <= 2'd2;
        end else if (guard_r != 2'd0) begin
            guard_r <= guard_r - 2'd1;
        end else begin
            guard_r <= guard_r;
        end
    end

    // Output stage and read pointer advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            read_pointer_r <= PTR_RESET;
            data_r         <= {DATA_WIDTH{1'b0}};
            valid_r        <= 1'b0;
        end else if (pop_s) begin
            read_pointer_r <= rotl(read_pointer_r, 1);
            data_r         <= sel_data_s;
            valid_r        <= 1'b1;
        end else if (valid_r && bus.ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.read_pointer = read_pointer_r;
    assign bus.data_o       = data_r;
    assign bus.valid_o      = valid_r;
    assign bus.empty_o      = ~can_read_s;
endmodule

// File: tb/tb_dc_token_ring_reader_mram.sv
// Bench for the token-ring read controller: random data/handshakes checked against an
// occupancy-count model with a two-edge flag delay and a pop-spacing rule.
module tb_dc_token_ring_reader_mram;
    localparam int D = 8;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    dc_token_ring_reader_mram_if #(.DATA_WIDTH(W), .BUFFER_DEPTH(D)) bus_if ();

    dc_token_ring_reader_mram #(.DATA_WIDTH(W), .BUFFER_DEPTH(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: counts of words written/popped, occupancy seen two edges late.
    int           wr_cnt, rd_cnt, s1, s2, cyc, last_pop;
    logic [W-1:0] wq[$];
    logic         m_valid;
    logic [W-1:0] m_data;

    function automatic logic [D-1:0] onehot(input int i);
        logic [D-1:0] v;
        v = {D{1'b0}};
        v[i % D] = 1'b1;
        return v;
    endfunction

    function automatic logic model_can();
        return (s2 >= 3) || ((s2 >= 1) && ((cyc + 1 - last_pop) >= 3));
    endfunction

    task automatic model_reset();
        wr_cnt = 0; rd_cnt = 0; s1 = 0; s2 = 0;
        wq.delete();
        m_valid = 1'b0; m_data = {W{1'b0}};
        last_pop = cyc - 1000;
        bus_if.write_pointer = onehot(0);
        bus_if.ready_i = 1'b0;
    endtask

    task automatic step(input bit do_wr, input bit rdy, input logic [W-1:0] wval);
        int   occ;
        logic pop;
        @(negedge clk);
        if (do_wr && ((wr_cnt - rd_cnt) < D - 1)) begin
            bus_if.buffer_data[(wr_cnt % D) * W +: W] = wval;
            wq.push_back(wval);
            wr_cnt++;
            bus_if.write_pointer = onehot(wr_cnt);
        end
        bus_if.ready_i = rdy;
        occ = wr_cnt - rd_cnt;
        pop = model_can() && (!m_valid || rdy);
        @(posedge clk);
        cyc++;
        s2 = s1;
        s1 = occ;
        if (pop) begin
            m_data = wq[rd_cnt];
            rd_cnt++;
            m_valid = 1'b1;
            last_pop = cyc;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus_if.read_pointer !== 8'h01) begin bad++; $display("FAIL reset_rp got=%h want=01", bus_if.read_pointer); end
        total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus_if.valid_o); end
        total++; if (bus_if.data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus_if.data_o); end
        total++; if (bus_if.empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus_if.empty_o); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 32'h0);
            total++;
            if (bus_if.read_pointer !== 8'h01 || bus_if.valid_o !== 1'b0 ||
                bus_if.data_o !== 32'h0 || bus_if.empty_o !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold i=%0d got rp=%h v=%b d=%h e=%b want rp=01 v=0 d=0 e=1",
                         i, bus_if.read_pointer, bus_if.valid_o, bus_if.data_o, bus_if.empty_o);
            end
        end
    endtask

    task automatic test_single_word();
        step(1'b1, 1'b1, 32'hA5A5_0001);
        total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL single_k got v=%b want=0", bus_if.valid_o); end
        step(1'b0, 1'b1, 32'h0);
        total++;
        if (bus_if.valid_o !== 1'b0 || bus_if.empty_o !== 1'b0) begin
            bad++; $display("FAIL single_k1 got v=%b e=%b want v=0 e=0", bus_if.valid_o, bus_if.empty_o);
        end
        step(1'b0, 1'b1, 32'h0);
        total++;
        if (bus_if.valid_o !== 1'b1 || bus_if.data_o !== 32'hA5A5_0001 || bus_if.read_pointer !== 8'h02) begin
            bad++;
            $display("FAIL single_k2 got v=%b d=%h rp=%h want v=1 d=a5a50001 rp=02",
                     bus_if.valid_o, bus_if.data_o, bus_if.read_pointer);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h0);
        total++;
        if (bus_if.valid_o !== 1'b0 || bus_if.read_pointer !== 8'h02 || bus_if.empty_o !== 1'b1) begin
            bad++;
            $display("FAIL single_after got v=%b rp=%h e=%b want v=0 rp=02 e=1",
                     bus_if.valid_o, bus_if.read_pointer, bus_if.empty_o);
        end
    endtask

    task automatic test_slow_path();
        logic [D-1:0] prev_rp;
        int           pop_cyc[$];
        logic [D-1:0] rp_seq[$];
        apply_reset(2);
        step(1'b1, 1'b1, $urandom);
        step(1'b1, 1'b1, $urandom);
        prev_rp = bus_if.read_pointer;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 32'h0);
            total++;
            if (bus_if.valid_o !== m_valid || bus_if.data_o !== m_data ||
                bus_if.read_pointer !== onehot(rd_cnt) || bus_if.empty_o !== ~model_can()) begin
                bad++;
                $display("FAIL slow_step i=%0d got v=%b d=%h rp=%h e=%b want v=%b d=%h rp=%h e=%b", i,
                         bus_if.valid_o, bus_if.data_o, bus_if.read_pointer, bus_if.empty_o,
                         m_valid, m_data, onehot(rd_cnt), ~model_can());
            end
            if (bus_if.read_pointer !== prev_rp) begin
                pop_cyc.push_back(cyc);
                rp_seq.push_back(bus_if.read_pointer);
            end
            prev_rp = bus_if.read_pointer;
        end
        total++;
        if (pop_cyc.size() != 2) begin
            bad++; $display("FAIL slow_count got=%0d want=2", pop_cyc.size());
        end else begin
            total++; if (pop_cyc[1] - pop_cyc[0] != 3) begin bad++; $display("FAIL slow_gap got=%0d want=3", pop_cyc[1] - pop_cyc[0]); end
            total++; if (rp_seq[0] !== 8'h02 || rp_seq[1] !== 8'h04) begin bad++; $display("FAIL slow_rp got=%h,%h want=02,04", rp_seq[0], rp_seq[1]); end
        end
        total++; if (bus_if.empty_o !== 1'b1) begin bad++; $display("FAIL slow_empty got=%b want=1", bus_if.empty_o); end
    endtask

    task automatic test_burst();
        int           written, npop, b2b, last_seen;
        bit           wrapped, wr;
        logic [D-1:0] prev_rp;
        apply_reset(2);
        written = 0; npop = 0; b2b = 0; last_seen = -10; wrapped = 1'b0;
        prev_rp = bus_if.read_pointer;
        for (int t = 0; t < 200; t++) begin
            wr = (written < 12) && ((wr_cnt - rd_cnt) < D - 1);
            step(wr, 1'b1, $urandom);
            if (wr) written++;
            total++;
            if (bus_if.valid_o !== m_valid || bus_if.data_o !== m_data ||
                bus_if.read_pointer !== onehot(rd_cnt) || bus_if.empty_o !== ~model_can()) begin
                bad++;
                $display("FAIL burst_step t=%0d got v=%b d=%h rp=%h e=%b want v=%b d=%h rp=%h e=%b", t,
                         bus_if.valid_o, bus_if.data_o, bus_if.read_pointer, bus_if.empty_o,
                         m_valid, m_data, onehot(rd_cnt), ~model_can());
            end
            if (bus_if.read_pointer !== prev_rp) begin
                npop++;
                if (cyc - last_seen == 1) b2b++;
                if (prev_rp === 8'h80 && bus_if.read_pointer === 8'h01) wrapped = 1'b1;
                last_seen = cyc;
            end
            prev_rp = bus_if.read_pointer;
            if (written == 12 && rd_cnt == 12 && !m_valid) break;
        end
        total++; if (npop != 12) begin bad++; $display("FAIL burst_pops got=%0d want=12", npop); end
        total++; if (!wrapped) begin bad++; $display("FAIL burst_wrap got=no want=80->01"); end
        total++; if (b2b == 0) begin bad++; $display("FAIL burst_b2b got=%0d want=>0", b2b); end
        total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL burst_drain got v=%b want=0", bus_if.valid_o); end
    endtask

    task automatic test_back_pressure();
        int n;
        apply_reset(2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom);
        n = 0;
        while (!m_valid && n < 20) begin step(1'b0, 1'b0, 32'h0); n++; end
        total++; if (bus_if.valid_o !== 1'b1) begin bad++; $display("FAIL bp_first got v=%b want=1", bus_if.valid_o); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0);
            total++;
            if (bus_if.valid_o !== 1'b1 || bus_if.data_o !== wq[0] || bus_if.read_pointer !== 8'h02) begin
                bad++;
                $display("FAIL bp_hold i=%0d got v=%b d=%h rp=%h want v=1 d=%h rp=02", i,
                         bus_if.valid_o, bus_if.data_o, bus_if.read_pointer, wq[0]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 32'h0);
            total++;
            if (bus_if.valid_o !== m_valid || bus_if.data_o !== m_data ||
                bus_if.read_pointer !== onehot(rd_cnt) || bus_if.empty_o !== ~model_can()) begin
                bad++;
                $display("FAIL bp_step i=%0d got v=%b d=%h rp=%h e=%b want v=%b d=%h rp=%h e=%b", i,
                         bus_if.valid_o, bus_if.data_o, bus_if.read_pointer, bus_if.empty_o,
                         m_valid, m_data, onehot(rd_cnt), ~model_can());
            end
        end
        total++; if (bus_if.read_pointer !== 8'h10) begin bad++; $display("FAIL bp_end got rp=%h want=10", bus_if.read_pointer); end
    endtask

    task automatic test_random();
        apply_reset(2);
        for (int t = 0; t < 400; t++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom);
            total++;
            if (bus_if.valid_o !== m_valid || bus_if.data_o !== m_data ||
                bus_if.read_pointer !== onehot(rd_cnt) || bus_if.empty_o !== ~model_can()) begin
                bad++;
                $display("FAIL rand_step t=%0d got v=%b d=%h rp=%h e=%b want v=%b d=%h rp=%h e=%b", t,
                         bus_if.valid_o, bus_if.data_o, bus_if.read_pointer, bus_if.empty_o,
                         m_valid, m_data, onehot(rd_cnt), ~model_can());
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset(2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, $urandom);
        total++; if (bus_if.valid_o !== 1'b1) begin bad++; $display("FAIL midrst_pre got v=%b want=1", bus_if.valid_o); end
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        total++; if (bus_if.read_pointer !== 8'h01) begin bad++; $display("FAIL midrst_rp got=%h want=01", bus_if.read_pointer); end
        total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus_if.valid_o); end
        total++; if (bus_if.data_o !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", bus_if.data_o); end
        total++; if (bus_if.empty_o !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b want=1", bus_if.empty_o); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 32'h0);
            total++;
            if (bus_if.valid_o !== 1'b0 || bus_if.empty_o !== 1'b1 || bus_if.read_pointer !== 8'h01) begin
                bad++;
                $display("FAIL midrst_after i=%0d got v=%b e=%b rp=%h want v=0 e=1 rp=01", i,
                         bus_if.valid_o, bus_if.empty_o, bus_if.read_pointer);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        cyc = 0;
        bus_if.buffer_data = {(D*W){1'b0}};
        model_reset();
        test_reset();
        test_single_word();
        test_slow_path();
        test_burst();
        test_back_pressure();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
